game_ms_timer: RTL and testbench
================================

Name: game_ms_timer

Overview:
- Upstream stage of the count-down display decoder; generates the free-running game millisecond count COUNT1 that the decoder maps to 3/2/1/0.
- Prescales CLK into ms ticks and counts ticks from 0 up to LIMIT after a START press, then holds LIMIT.
- Reports run status and a one-cycle completion pulse to game control.

Parameters:
- TICK_DIV, 1000: CLK cycles per ms tick (1 MHz CLK); legal range ≥2.
- LIMIT, 3000: terminal COUNT1 value; matches the decoder's 3-2-1 window; legal range 1 to 2^32-1.
- DIV_W, 16: prescaler width; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- START  in  1  level input from debounced button; internally rising-edge detected.
- ABORT  in  1  level input; returns the block to idle.
- COUNT1  out  32  elapsed ms since start; feeds the count-down decoder.
- RUNNING  out  1  high while in RUN.
- TICK  out  1  one-cycle pulse, coincident with each COUNT1 increment.
- DONE  out  1  one-cycle pulse, coincident with COUNT1 reaching LIMIT.

Behaviour:
- Reset (RESETN=0, async): state IDLE, COUNT1=0, prescaler=0, RUNNING=0, TICK=0, DONE=0, start_d=1. Because start_d resets to 1, a START held high through reset release does not trigger.
- start_rise = START & ~start_d, where start_d is START registered every cycle.
- States: IDLE, RUN, HOLD. All outputs are registered.
- IDLE:
  - start_rise at edge k → RUN at edge k, with COUNT1=0, prescaler=0, RUNNING=1.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - At an edge with prescaler==TICK_DIV-1: prescaler→0, COUNT1→COUNT1+1, TICK=1 for one cycle.
  - COUNT1 therefore becomes n exactly n·TICK_DIV edges after the start edge.
  - If the increment produces LIMIT: at that edge, state→HOLD, RUNNING=0, DONE=1 for one cycle, TICK=1.
  - start_rise during RUN is ignored; there is no restart mid-run.
- HOLD:
  - COUNT1 is held at LIMIT and the prescaler is frozen.
  - start_rise → RUN with COUNT1=0, prescaler=0, same as from IDLE.
- ABORT=1 at any edge, in any state: → IDLE, COUNT1=0, prescaler=0, RUNNING=0, TICK=0, DONE=0.
  - ABORT has priority over start_rise and over tick/terminal events in the same cycle.
  - start_d still updates during ABORT.
- COUNT1 never wraps; it cannot exceed LIMIT.
- TICK and DONE are never asserted in IDLE or HOLD, except for the terminal-edge DONE/TICK pulse when entering HOLD.
- Reset asserted mid-run: immediate return to the reset values, independent of CLK.

Optional Feature:
- Macro: GAME_TIMER_PAUSE_EN.
- Defined: adds input port PAUSE (1 bit).
  - While PAUSE=1 in RUN, the prescaler and COUNT1 freeze and no TICK is issued; RUNNING stays 1.
  - Counting resumes from the frozen prescaler value on the first edge with PAUSE=0.
  - start_rise is still ignored while paused; ABORT still works.
  - PAUSE has no effect in IDLE or HOLD.
- Undefined: no PAUSE port; RUN always counts.

Decomposition:
- Package game_timer_pkg contains:
  - State typedef/encoding: IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - Default constants: TICK_DIV_DEF=1000, LIMIT_DEF=3000, COUNT_W=32.
- Sub-module edge_rise_det: 1-bit register plus AND, with reset value of the register selectable. It owns start_d. The main FSM/counters stay in game_ms_timer.

Test Plan (TICK_DIV=4, LIMIT=10 unless noted):
- Basic run: reset, START rises at edge k → RUNNING=1 at k; COUNT1=1 at k+4, 2 at k+8; COUNT1=10, DONE=1 (single cycle), RUNNING=0 at k+40; COUNT1 stays 10 for 20 more cycles.
- Start held through reset: START=1 before and after RESETN release → stays IDLE, COUNT1=0. After START drops and re-rises → RUN.
- Restart/ignore: START re-pulsed at k+10 during RUN → COUNT1 unaffected (10 at k+40). START pulse in HOLD → COUNT1=0, RUNNING=1, then 1 four edges later.
- ABORT priority: ABORT=1 on the same edge as start_rise in IDLE → remains IDLE. ABORT at k+39 (the cycle before terminal) → COUNT1=0, no DONE ever pulses.
- Async reset mid-run: RESETN low between edges at COUNT1=5 → COUNT1=0, RUNNING=0 immediately, before the next CLK.
- With GAME_TIMER_PAUSE_EN: PAUSE high for 7 cycles starting at COUNT1=3 → COUNT1 holds 3, no TICK; DONE arrives 7 edges later than unpaused (k+47).

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and defaults for the game millisecond timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_timer_pkg;

    localparam int unsigned TICK_DIV_DEF = 1000;
    localparam int unsigned LIMIT_DEF    = 3000;
    localparam int unsigned COUNT_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: registers the input and flags a 0->1 transition.
// Latency: rise is combinational from d against the previous-cycle sample.
// Backpressure: none; the sample register updates every cycle.
//
// Ports: CLK, RESETN (async active-low), d (level in), rise (d & ~d_prev).
// RST_VAL selects the reset value of the sample register; setting it to 1
// suppresses a spurious edge when d is already high at reset release.
module edge_rise_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic d,
    output logic rise
);

    logic d_prev;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            d_prev <= RST_VAL;
        end else begin
            d_prev <= d;
        end
    end

    assign rise = d & ~d_prev;

endmodule

// File: rtl/game_ms_timer.sv
// Game ms timer: prescales CLK into ms ticks, counts 0..LIMIT after START, then holds.
// Latency: all outputs registered; RUNNING rises on the START edge, COUNT1=n at n*TICK_DIV edges later.
// Backpressure: none; START/ABORT are level inputs sampled every cycle, ABORT always wins.
//
// Ports: CLK, RESETN (async active-low), START (level, rising edge starts a run),
//        ABORT (level, forces idle), PAUSE (only with GAME_TIMER_PAUSE_EN),
//        COUNT1 (elapsed ms), RUNNING, TICK (pulse per increment), DONE (pulse at LIMIT).
// Build option: define GAME_TIMER_PAUSE_EN to add the PAUSE input.
module game_ms_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned LIMIT    = LIMIT_DEF,
    parameter int unsigned DIV_W    = 16
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               START,
    input  logic               ABORT,
`ifdef GAME_TIMER_PAUSE_EN
    input  logic               PAUSE,
`endif
    output logic [COUNT_W-1:0] COUNT1,
    output logic               RUNNING,
    output logic               TICK,
    output logic               DONE
);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] LIMIT_V  = COUNT_W'(LIMIT);

    timer_state_t       state, state_nxt;
    logic [DIV_W-1:0]   presc, presc_nxt;
    logic [COUNT_W-1:0] count_nxt, count_inc;
    logic               tick_nxt, done_nxt;
    logic               start_rise;
    logic               pause_act;

`ifdef GAME_TIMER_PAUSE_EN
    assign pause_act = PAUSE;
`else
    assign pause_act = 1'b0;
`endif

    // Register resets high so a button held through reset release is not a start.
    edge_rise_det #(.RST_VAL(1'b1)) u_start_det (
        .CLK    (CLK),
        .RESETN (RESETN),
        .d      (START),
        .rise   (start_rise)
    );

    assign count_inc = COUNT1 + COUNT_W'(1);

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        count_nxt = COUNT1;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE, HOLD: begin
                if (start_rise) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                    count_nxt = '0;
                end
            end
            RUN: begin
                // Restart is ignored here; pause freezes both counters.
                if (!pause_act) begin
                    if (presc == DIV_LAST) begin
                        presc_nxt = '0;
                        count_nxt = count_inc;
                        tick_nxt  = 1'b1;
                        if (count_inc == LIMIT_V) begin
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        presc_nxt = presc + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                presc_nxt = '0;
                count_nxt = '0;
            end
        endcase

        // ABORT overrides start and terminal events in the same cycle.
        if (ABORT) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            count_nxt = '0;
            tick_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            presc   <= '0;
            COUNT1  <= '0;
            RUNNING <= 1'b0;
            TICK    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            COUNT1  <= count_nxt;
            RUNNING <= (state_nxt == RUN);
            TICK    <= tick_nxt;
            DONE    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_game_ms_timer.sv
// Bench for game_ms_timer with TICK_DIV=4, LIMIT=10: directed scenarios plus random
// START/ABORT(/PAUSE) traffic, checked every cycle against an elapsed-time model.
// No backpressure; inputs change 1 ns after the rising edge, outputs compared on the falling edge.
module tb_game_ms_timer;

    localparam int unsigned TD  = 4;
    localparam int unsigned LIM = 10;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic        pause_in = 1'b0;
    logic [31:0] COUNT1;
    logic        RUNNING, TICK, DONE;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    game_ms_timer #(.TICK_DIV(TD), .LIMIT(LIM), .DIV_W(3)) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .START   (START),
        .ABORT   (ABORT),
`ifdef GAME_TIMER_PAUSE_EN
        .PAUSE   (pause_in),
`endif
        .COUNT1  (COUNT1),
        .RUNNING (RUNNING),
        .TICK    (TICK),
        .DONE    (DONE)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: count edges spent running (not paused) since the start;
    // COUNT1 is that elapsed time divided by TICK_DIV.
    bit          m_run, m_hold, m_tick, m_done, m_prev_start, m_rise;
    int unsigned m_elapsed;
    longint      m_count;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_run = 0; m_hold = 0; m_tick = 0; m_done = 0;
            m_prev_start = 1; m_elapsed = 0; m_count = 0;
        end else begin
            m_rise = START && !m_prev_start;
            m_prev_start = START;
            m_tick = 0;
            m_done = 0;
            if (ABORT) begin
                m_run = 0; m_hold = 0; m_elapsed = 0; m_count = 0;
            end else if (m_run) begin
`ifdef GAME_TIMER_PAUSE_EN
                if (!pause_in) begin
`else
                begin
`endif
                    m_elapsed++;
                    if (m_elapsed % TD == 0) begin
                        m_tick = 1;
                        m_count = m_elapsed / TD;
                        if (m_count == LIM) begin
                            m_done = 1; m_run = 0; m_hold = 1;
                        end
                    end
                end
            end else if (m_rise) begin
                m_run = 1; m_hold = 0; m_elapsed = 0; m_count = 0;
            end
        end
    end

    always @(negedge CLK) begin
        check("count1", COUNT1, m_count);
        check("running", RUNNING, m_run);
        check("tick", TICK, m_tick);
        check("done", DONE, m_done);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with START already high: release must not start a run.
        START = 1'b1;
        edges(2);
        check("rst_count1", COUNT1, 0);
        check("rst_running", RUNNING, 0);
        #2 RESETN = 1'b1;
        edges(5);
        check("held_start_idle", RUNNING, 0);
        check("held_start_count", COUNT1, 0);
        START = 1'b0;
        edges(1);
        START = 1'b1;
        edges(1);
        check("rerise_running", RUNNING, 1);
        ABORT = 1'b1;
        edges(1);
        ABORT = 1'b0;
        START = 1'b0;
        edges(1);

        // Basic run with a mid-run restart attempt; edge k is the first edge below.
        START = 1'b1;
        edges(1);
        check("k_running", RUNNING, 1);
        check("k_count1", COUNT1, 0);
        edges(4);
        check("k4_count1", COUNT1, 1);
        check("k4_tick", TICK, 1);
        edges(4);
        check("k8_count1", COUNT1, 2);
        START = 1'b0;
        edges(2);
        START = 1'b1;
        edges(29);
        check("k39_count1", COUNT1, 9);
        check("k39_done", DONE, 0);
        edges(1);
        check("k40_count1", COUNT1, 10);
        check("k40_done", DONE, 1);
        check("k40_running", RUNNING, 0);
        START = 1'b0;
        edges(1);
        check("k41_done", DONE, 0);
        for (int i = 0; i < 20; i++) begin
            edges(1);
            check("hold_count1", COUNT1, 10);
        end

        // Restart from HOLD.
        START = 1'b1;
        edges(1);
        check("hold_restart_count1", COUNT1, 0);
        check("hold_restart_running", RUNNING, 1);
        edges(4);
        check("hold_restart_k4", COUNT1, 1);

        // ABORT coincident with a start edge in IDLE.
        ABORT = 1'b1;
        edges(1);
        check("abort_idle", RUNNING, 0);
        START = 1'b0;
        ABORT = 1'b0;
        edges(1);
        START = 1'b1;
        ABORT = 1'b1;
        edges(1);
        check("abort_vs_start", RUNNING, 0);
        ABORT = 1'b0;
        edges(3);
        check("abort_vs_start_after", RUNNING, 0);

        // ABORT on the edge before terminal.
        START = 1'b0;
        edges(1);
        START = 1'b1;
        edges(1);
        edges(38);
        check("pre_abort_count1", COUNT1, 9);
        ABORT = 1'b1;
        edges(1);
        check("late_abort_count1", COUNT1, 0);
        check("late_abort_done", DONE, 0);
        ABORT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            check("late_abort_no_done", DONE, 0);
        end

        // Async reset mid-run, between clock edges.
        START = 1'b0;
        edges(1);
        START = 1'b1;
        edges(1);
        edges(20);
        check("pre_rst_count1", COUNT1, 5);
        #2 RESETN = 1'b0;
        #1;
        check("async_rst_count1", COUNT1, 0);
        check("async_rst_running", RUNNING, 0);
        edges(2);
        RESETN = 1'b1;
        edges(2);
        check("post_rst_idle", RUNNING, 0);

`ifdef GAME_TIMER_PAUSE_EN
        // Pause for 7 edges at COUNT1=3 pushes DONE from k+40 to k+47.
        START = 1'b0;
        edges(1);
        START = 1'b1;
        edges(1);
        edges(12);
        check("pause_pre_count1", COUNT1, 3);
        pause_in = 1'b1;
        edges(7);
        check("pause_hold_count1", COUNT1, 3);
        check("pause_running", RUNNING, 1);
        pause_in = 1'b0;
        edges(27);
        check("pause_k46_done", DONE, 0);
        edges(1);
        check("pause_k47_done", DONE, 1);
        check("pause_k47_count1", COUNT1, 10);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) START = ~START;
            ABORT = ($urandom_range(0, 59) == 0);
`ifdef GAME_TIMER_PAUSE_EN
            if ($urandom_range(0, 19) == 0) pause_in = ~pause_in;
`endif
            if (i == 1500) begin
                #2 RESETN = 1'b0;
                #2 RESETN = 1'b1;
            end
            edges(1);
        end

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
